// File: rtl/clock_key_ctrl.sv
// clock_key_ctrl: debounced MODE/INC keys drive the digit select, the increment pulse with auto-repeat, and the edit blink
module clock_key_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000,
  parameter int BLINK_CYC    = 12_500_000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic [3:0] key_en,
  output logic       clock,
  output logic       set_mode,
  output logic       blink
);
  localparam int DW   = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RMAX = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  localparam int BW   = BLINK_CYC > 1 ? $clog2(BLINK_CYC) : 1;
  typedef enum logic [2:0] {RUN, SET_HT, SET_HO, SET_MT, SET_MO} state_t;
  logic [1:0]    w_raw, r_sync1, r_sync2, r_deb, r_deb_d, w_press;
  logic [DW-1:0] r_db_cnt [2];
  state_t        r_state, w_state_nxt;
  logic [3:0]    w_key_en_nxt;
  logic          w_mode_press, w_inc_press, w_set;
  logic          w_first, w_rep_run, w_rep_fire, w_clock_nxt, w_blink_clr;
  logic [RW-1:0] r_rep_cnt, w_rep_thr;
  logic          r_rep_arm, r_rep_fast;
  logic [BW-1:0] r_blink_cnt;
  assign w_raw = {key_inc_n, key_mode_n};
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      r_sync1     <= 2'b11;
      r_sync2     <= 2'b11;
      r_deb       <= 2'b11;
      r_deb_d     <= 2'b11;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int k = 0; k < 2; k++)
        if (r_sync2[k] == r_deb[k]) r_db_cnt[k] <= '0;
        else if (r_db_cnt[k] == DW'(DEBOUNCE_CYC - 1)) begin
          r_deb[k]    <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
    end
  assign w_press      = r_deb_d & ~r_deb;
  assign w_mode_press = w_press[0];
  assign w_inc_press  = w_press[1];
  assign w_set        = r_state != RUN;
  always_comb begin
    w_state_nxt  = r_state;
    w_key_en_nxt = 4'b0000;
    if (w_mode_press)
      case (r_state)
        RUN:     w_state_nxt = SET_HT;
        SET_HT:  w_state_nxt = SET_HO;
        SET_HO:  w_state_nxt = SET_MT;
        SET_MT:  w_state_nxt = SET_MO;
        default: w_state_nxt = RUN;
      endcase
    case (w_state_nxt)
      SET_HT:  w_key_en_nxt = 4'b1000;
      SET_HO:  w_key_en_nxt = 4'b0100;
      SET_MT:  w_key_en_nxt = 4'b0010;
      SET_MO:  w_key_en_nxt = 4'b0001;
      default: w_key_en_nxt = 4'b0000;
    endcase
  end
  // MODE always wins, so clock can never rise together with a key_en change
  assign w_first     = w_set & w_inc_press & ~w_mode_press;
  assign w_rep_run   = r_rep_arm & ~r_deb[1] & w_set & ~w_mode_press;
  assign w_rep_thr   = r_rep_fast ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1);
  assign w_rep_fire  = w_rep_run & (r_rep_cnt == w_rep_thr);
  assign w_clock_nxt = w_first | w_rep_fire;
  assign w_blink_clr = (w_state_nxt != r_state) | w_clock_nxt | (w_state_nxt == RUN);
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      r_state  <= RUN;
      key_en   <= 4'b0000;
      set_mode <= 1'b0;
      clock    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      key_en   <= w_key_en_nxt;
      set_mode <= w_state_nxt != RUN;
      clock    <= w_clock_nxt;
    end
  // Repeat stays disarmed after a MODE press or release until a fresh INC press
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      r_rep_arm  <= 1'b0;
      r_rep_fast <= 1'b0;
      r_rep_cnt  <= '0;
    end else if (w_first) begin
      r_rep_arm  <= 1'b1;
      r_rep_fast <= 1'b0;
      r_rep_cnt  <= '0;
    end else if (!w_rep_run) begin
      r_rep_arm  <= 1'b0;
      r_rep_fast <= 1'b0;
      r_rep_cnt  <= '0;
    end else if (w_rep_fire) begin
      r_rep_fast <= 1'b1;
      r_rep_cnt  <= '0;
    end else r_rep_cnt <= r_rep_cnt + 1'b1;
  always_ff @(posedge mclk or posedge rst)
    if (rst) begin
      r_blink_cnt <= '0;
      blink       <= 1'b0;
    end else if (w_blink_clr) begin
      r_blink_cnt <= '0;
      blink       <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_CYC - 1)) begin
      r_blink_cnt <= '0;
      blink       <= ~blink;
    end else r_blink_cnt <= r_blink_cnt + 1'b1;
endmodule
